csoc_scan_emu: RTL
==================

CSOC_SCAN_EMU -- requirements
Module: csoc_scan_emu

Interface
REQ-001 The block SHALL have parameter NCHAINS, default 4: number of independent scan chains, legal range 1..16.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 480: flip-flops per chain, legal range 2..4096.
REQ-003 The block SHALL have derived localparam CNT_W = $clog2(CHAIN_LEN+1).
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port test_tm_i, input, 1 bit: test mode (1 = test, 0 = functional).
REQ-007 The block SHALL have the port test_se_i, input, 1 bit: scan enable.
REQ-008 The block SHALL have the port capture_i, input, 1 bit: capture-cycle request, test mode only.
REQ-009 The block SHALL have the port scan_in_i, input, NCHAINS bits: serial input, one bit per chain.
REQ-010 The block SHALL have the port scan_out_o, output, NCHAINS bits: serial output, one bit per chain.
REQ-011 The block SHALL have the port shift_cnt_o, output, CNT_W bits: shifts in the current scan burst.
REQ-012 The block SHALL have the port shift_done_o, output, 1 bit: one-cycle pulse when a full chain length has been shifted.
REQ-013 The block SHALL have the port state_o, output, 2 bits: operation performed at the last clock edge.

Function
REQ-014 The block SHALL select exactly one operation per cycle from the current inputs, using this priority: rst_i, then FUNC (test_tm_i=0), then SHIFT (test_tm_i=1 and test_se_i=1), then CAPTURE (test_tm_i=1, test_se_i=0, capture_i=1), then HOLD.
REQ-015 In SHIFT, each chain c SHALL load chain[c][0] <= scan_in_i[c] and chain[c][k] <= chain[c][k-1] for k = 1..CHAIN_LEN-1.
REQ-016 In CAPTURE and in FUNC, each chain SHALL rotate left by one bit: chain[c][0] <= chain[c][CHAIN_LEN-1], and bit k <= bit k-1 for all other bits.
REQ-017 In HOLD, all chain contents SHALL be unchanged.
REQ-018 scan_out_o[c] SHALL be driven directly from flop chain[c][CHAIN_LEN-1], with no extra pipeline stage and no combinational path from any input.
REQ-019 shift_cnt_o SHALL increment by 1 on each SHIFT edge and saturate at CHAIN_LEN, and SHALL clear to 0 on any non-SHIFT edge.
REQ-020 shift_done_o SHALL be 1 for exactly the one cycle after the edge where shift_cnt_o goes from CHAIN_LEN-1 to CHAIN_LEN, and 0 while saturated.
REQ-021 state_o SHALL be registered, with encoding FUNC=0, SHIFT=1, CAPTURE=2, HOLD=3.
REQ-022 A capture_i pulse that coincides with test_se_i=1 SHALL be ignored (SHIFT wins), and it SHALL NOT be queued.
REQ-023 A test_tm_i drop in the middle of a burst SHALL switch the block to FUNC on that edge and clear shift_cnt_o, with no shift_done_o pulse.
REQ-024 Chains SHALL be fully independent: no bit ever crosses between chains in any operation.

Reset
REQ-025 On any edge with rst_i=1, all chain flops, shift_cnt_o and shift_done_o SHALL be 0, and state_o SHALL be 3 (HOLD).
REQ-026 A reset asserted in the middle of a shift or capture SHALL override that operation on the same edge, with no partial update.
REQ-027 After reset, scan_out_o SHALL be all zeros.

Structure
REQ-028 The operation encoding (a 2-bit enum: FUNC, SHIFT, CAPTURE, HOLD) SHALL live in the shared package csoc_pkg.
REQ-029 One chain SHALL be implemented as sub-module csoc_scan_chain (parameter CHAIN_LEN; ports clk_i, rst_i, op, sin, sout), instantiated NCHAINS times through a generate loop.
REQ-030 The top level SHALL contain only the operation decode, the shift counter, the done pulse and state_o.

Verification (NCHAINS=2, CHAIN_LEN=8)
REQ-031 Shift bits 1,0,1,0,0,1,0,1 (first to last) into chain 0 and 0s into chain 1 SHALL result in chain0=0xA5, chain1=0x00, scan_out_o=2'b01, shift_cnt_o=8, and shift_done_o pulsed exactly once.
REQ-032 From chain0=0xA5, one CAPTURE edge followed by HOLD SHALL result in chain0=0x4B, state_o=2 then 3, and shift_cnt_o=0.
REQ-033 From chain0=0xA5, three FUNC edges SHALL result in chain0=0x96 after the second edge and 0x2D after the third; capture_i asserted with test_se_i=1 SHALL still perform SHIFT.
REQ-034 Twelve consecutive SHIFT edges SHALL result in shift_cnt_o saturating at 8, a single shift_done_o pulse, and chain0 holding the last 8 bits shifted in.
REQ-035 Five shifts, then test_tm_i=0 for one cycle, then shifting resumed SHALL result in the count clearing to 0 and done firing only after 8 further shifts.
REQ-036 rst_i asserted during the 4th shift SHALL, on the next cycle, leave all chains 0, shift_cnt_o=0, state_o=3, and scan_out_o=0.

Source files
------------

// File: rtl/csoc_pkg.sv
// Shared definitions for the scan-chain emulator: operation encoding and
// the priority decode that selects one operation per clock.
package csoc_pkg;

  // Operation performed at a clock edge; also the registered state_o value.
  typedef enum logic [1:0] {
    OP_FUNC    = 2'd0,
    OP_SHIFT   = 2'd1,
    OP_CAPTURE = 2'd2,
    OP_HOLD    = 2'd3
  } op_e;

  // Priority decode (reset is handled by the flops themselves):
  // functional mode first, then scan shift, then capture, else hold.
  function automatic op_e decode_op(input logic tm, input logic se, input logic cap);
    if (!tm)     return OP_FUNC;
    else if (se) return OP_SHIFT;
    else if (cap) return OP_CAPTURE;
    else         return OP_HOLD;
  endfunction

endpackage

// File: rtl/csoc_scan_emu_if.sv
// Signal bundle for the scan-test side of csoc_scan_emu. The controller
// (tester) side drives mode/scan inputs and observes the block's outputs.
interface csoc_scan_emu_if #(
  parameter int NCHAINS = 4,
  parameter int CNT_W   = 9
);

  logic               test_tm;
  logic               test_se;
  logic               capture;
  logic [NCHAINS-1:0] scan_in;
  logic [NCHAINS-1:0] scan_out;
  logic [CNT_W-1:0]   shift_cnt;
  logic               shift_done;
  logic [1:0]         state;

  // Tester side: drives controls and serial data, observes results.
  modport master (
    output test_tm, test_se, capture, scan_in,
    input  scan_out, shift_cnt, shift_done, state
  );

  // Block side: consumes controls, produces serial data and status.
  modport slave (
    input  test_tm, test_se, capture, scan_in,
    output scan_out, shift_cnt, shift_done, state
  );

endinterface

// File: rtl/csoc_scan_chain.sv
// One scan chain of CHAIN_LEN flops. Bit 0 is the serial entry point,
// bit CHAIN_LEN-1 drives the serial output straight from its flop.
module csoc_scan_chain
  import csoc_pkg::*;
#(
  parameter int CHAIN_LEN = 480
) (
  input  logic clk_i,
  input  logic rst_i,
  input  op_e  op,
  input  logic sin,
  output logic sout
);

  logic [CHAIN_LEN-1:0] chain_q;

  // Chain update: shift in serial data, rotate on capture/functional, else hold.
  // NOTE: this is a flop array but it must still be reset -- scan_out has to
  // read all zeros after reset, so every bit gets the synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so each bit takes its neighbour's
      // pre-edge value; blocking would ripple one bit through the whole chain.
      unique case (op)
        OP_SHIFT:            chain_q <= {chain_q[CHAIN_LEN-2:0], sin};
        OP_FUNC, OP_CAPTURE: chain_q <= {chain_q[CHAIN_LEN-2:0], chain_q[CHAIN_LEN-1]};
        default:             chain_q <= chain_q;
      endcase
    end
  end

  assign sout = chain_q[CHAIN_LEN-1];

endmodule

// File: rtl/csoc_scan_emu.sv
// Scan-chain emulator top: operation decode, shift-burst counter, done
// pulse and registered operation report. Chains live in csoc_scan_chain.
module csoc_scan_emu
  import csoc_pkg::*;
#(
  parameter  int NCHAINS   = 4,
  parameter  int CHAIN_LEN = 480,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               test_tm_i,
  input  logic               test_se_i,
  input  logic               capture_i,
  input  logic [NCHAINS-1:0] scan_in_i,
  output logic [NCHAINS-1:0] scan_out_o,
  output logic [CNT_W-1:0]   shift_cnt_o,
  output logic               shift_done_o,
  output logic [1:0]         state_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  op_e              op_d, op_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;

  // Next-operation decode plus counter/done next-state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    op_d   = decode_op(test_tm_i, test_se_i, capture_i);
    cnt_d  = '0;
    done_d = 1'b0;
    if (op_d == OP_SHIFT) begin
      cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  // Registered operation report, burst counter and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q   <= OP_HOLD;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign state_o      = op_q;
  assign shift_cnt_o  = cnt_q;
  assign shift_done_o = done_q;

  for (genvar c = 0; c < NCHAINS; c++) begin : g_chain
    csoc_scan_chain #(
      .CHAIN_LEN (CHAIN_LEN)
    ) u_chain (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .op    (op_d),
      .sin   (scan_in_i[c]),
      .sout  (scan_out_o[c])
    );
  end

endmodule
